// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S stream engine.
package i2s_pkg;

  // Slot tracking state of the serial engine.
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_LEFT  = 2'd1,
    SLOT_RIGHT = 2'd2
  } slot_e;

  // Depth of the synchronisers on the codec-driven inputs.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with look-ahead read data and occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array: write the incoming entry at the write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/i2s_stream_engine.sv
// I2S slave engine: MCLK generation, TX FIFO serialisation onto DIN and
// stereo capture from DOUT, timed by the codec-driven SCLK/LRCLK.
module i2s_stream_engine
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MCLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [2*DATA_W-1:0]           tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [DATA_W-1:0]             rx_left,
  output logic [DATA_W-1:0]             rx_right,
  output logic                          rx_valid,
  output logic                          underrun,
  input  logic                          clear_flags,
  output logic                          i2s_mclk,
  input  logic                          i2s_sclk,
  input  logic                          i2s_lrclk,
  output logic                          i2s_din,
  input  logic                          i2s_dout
);

  localparam int MC_W  = $clog2(MCLK_DIV);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [MC_W-1:0]  MC_WRAP  = MC_W'(MCLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_M1  = CNT_W'(DATA_W - 1);

  // MCLK divider
  logic [MC_W-1:0] mclk_cnt_r;
  logic            mclk_r;

  // Input synchronisers and edge history
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] lrclk_sync_r;
  logic [SYNC_STAGES-1:0] dout_sync_r;
  logic                   sclk_q_r;
  logic                   lrclk_at_rise_r;
  logic                   sclk_s, lrclk_s, dout_s;
  logic                   sclk_rise_s, sclk_fall_s;
  logic                   slot_start_s, left_start_s, right_start_s;

  // Slot engine
  slot_e                  state_r;
  logic [CNT_W-1:0]       rise_cnt_r;
  logic [CNT_W-1:0]       fall_cnt_r;
  logic [DATA_W-1:0]      tx_shift_r;
  logic [DATA_W-1:0]      tx_hold_r;
  logic                   din_r;
  logic [DATA_W-1:0]      rx_shift_l_r;
  logic [DATA_W-1:0]      rx_shift_r_r;
  logic                   left_done_r;
  logic [DATA_W-1:0]      rx_left_r;
  logic [DATA_W-1:0]      rx_right_r;
  logic                   rx_valid_r;
  logic                   underrun_r;

  // FIFO interface
  logic                   pop_req_s;
  logic                   underrun_set_s;
  logic [2*DATA_W-1:0]    fifo_rdata_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

  assign sclk_s  = sclk_sync_r[SYNC_STAGES-1];
  assign lrclk_s = lrclk_sync_r[SYNC_STAGES-1];
  assign dout_s  = dout_sync_r[SYNC_STAGES-1];

  assign sclk_rise_s    = sclk_s && !sclk_q_r;
  assign sclk_fall_s    = !sclk_s && sclk_q_r;
  assign slot_start_s   = sclk_rise_s && (lrclk_s != lrclk_at_rise_r);
  assign left_start_s   = slot_start_s && !lrclk_s;
  assign right_start_s  = slot_start_s && lrclk_s;
  assign pop_req_s      = enable && left_start_s;
  assign underrun_set_s = pop_req_s && fifo_empty_s;

  sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_valid),
    .pop     (pop_req_s),
    .wdata   (tx_data),
    .rdata   (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (tx_level)
  );

  assign tx_ready = !fifo_full_s;
  assign i2s_mclk = mclk_r;
  assign i2s_din  = din_r;
  assign rx_left  = rx_left_r;
  assign rx_right = rx_right_r;
  assign rx_valid = rx_valid_r;
  assign underrun = underrun_r;

  // Free-running MCLK: toggle every MCLK_DIV/2 system clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt_r <= {MC_W{1'b0}};
      mclk_r     <= 1'b0;
    end else if (mclk_cnt_r == MC_WRAP) begin
      mclk_cnt_r <= {MC_W{1'b0}};
      mclk_r     <= !mclk_r;
    end else begin
      mclk_cnt_r <= mclk_cnt_r + MC_W'(1);
    end
  end

  // Equal-depth synchronisers so SCLK, LRCLK and DOUT stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_r  <= {SYNC_STAGES{1'b0}};
      lrclk_sync_r <= {SYNC_STAGES{1'b0}};
      dout_sync_r  <= {SYNC_STAGES{1'b0}};
      sclk_q_r     <= 1'b0;
    end else begin
      sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], i2s_sclk};
      lrclk_sync_r <= {lrclk_sync_r[SYNC_STAGES-2:0], i2s_lrclk};
      dout_sync_r  <= {dout_sync_r[SYNC_STAGES-2:0], i2s_dout};
      sclk_q_r     <= sclk_s;
    end
  end

  // Slot state machine with TX shifting, RX capture and the underrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= SLOT_IDLE;
      lrclk_at_rise_r <= 1'b0;
      rise_cnt_r      <= {CNT_W{1'b0}};
      fall_cnt_r      <= {CNT_W{1'b0}};
      tx_shift_r      <= {DATA_W{1'b0}};
      tx_hold_r       <= {DATA_W{1'b0}};
      din_r           <= 1'b0;
      rx_shift_l_r    <= {DATA_W{1'b0}};
      rx_shift_r_r    <= {DATA_W{1'b0}};
      left_done_r     <= 1'b0;
      rx_left_r       <= {DATA_W{1'b0}};
      rx_right_r      <= {DATA_W{1'b0}};
      rx_valid_r      <= 1'b0;
      underrun_r      <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (sclk_rise_s) lrclk_at_rise_r <= lrclk_s;
      // A new underrun outranks a simultaneous clear request.
      if (underrun_set_s)   underrun_r <= 1'b1;
      else if (clear_flags) underrun_r <= 1'b0;

      if (!enable) begin
        state_r     <= SLOT_IDLE;
        din_r       <= 1'b0;
        left_done_r <= 1'b0;
      end else if (left_start_s) begin
        // Frame start: take the next stereo pair, or send silence if none.
        state_r     <= SLOT_LEFT;
        rise_cnt_r  <= {CNT_W{1'b0}};
        fall_cnt_r  <= {CNT_W{1'b0}};
        left_done_r <= 1'b0;
        if (fifo_empty_s) begin
          tx_shift_r <= {DATA_W{1'b0}};
          tx_hold_r  <= {DATA_W{1'b0}};
        end else begin
          tx_shift_r <= fifo_rdata_s[2*DATA_W-1:DATA_W];
          tx_hold_r  <= fifo_rdata_s[DATA_W-1:0];
        end
      end else begin
        case (state_r)
          SLOT_IDLE: begin
            // Right starts are ignored until a left start aligns the frame.
            din_r <= 1'b0;
          end
          SLOT_LEFT, SLOT_RIGHT: begin
            if (right_start_s) begin
              state_r    <= SLOT_RIGHT;
              rise_cnt_r <= {CNT_W{1'b0}};
              fall_cnt_r <= {CNT_W{1'b0}};
              tx_shift_r <= tx_hold_r;
            end else begin
              if (sclk_rise_s && (rise_cnt_r != LAST_BIT)) begin
                rise_cnt_r <= rise_cnt_r + CNT_W'(1);
                if (state_r == SLOT_LEFT) begin
                  rx_shift_l_r <= {rx_shift_l_r[DATA_W-2:0], dout_s};
                  if (rise_cnt_r == LAST_M1) left_done_r <= 1'b1;
                end else begin
                  rx_shift_r_r <= {rx_shift_r_r[DATA_W-2:0], dout_s};
                  if ((rise_cnt_r == LAST_M1) && left_done_r) begin
                    rx_left_r   <= rx_shift_l_r;
                    rx_right_r  <= {rx_shift_r_r[DATA_W-2:0], dout_s};
                    rx_valid_r  <= 1'b1;
                    left_done_r <= 1'b0;
                  end
                end
              end
              if (sclk_fall_s) begin
                if (fall_cnt_r != LAST_BIT) begin
                  din_r      <= tx_shift_r[DATA_W-1];
                  tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                  fall_cnt_r <= fall_cnt_r + CNT_W'(1);
                end else begin
                  din_r <= 1'b0;
                end
              end
            end
          end
          default: begin
            state_r <= SLOT_IDLE;
            din_r   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_stream_engine.sv
// Directed/randomised bench: a codec model drives SCLK=clk/16 with 32-bit
// slots; a queue-based model predicts DIN slots, RX pairs, level and flags.
module tb_i2s_stream_engine;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic [2*W-1:0] tx_data = '0;
  logic           tx_valid = 1'b0;
  logic           tx_ready;
  logic [3:0]     tx_level;
  logic [W-1:0]   rx_left, rx_right;
  logic           rx_valid;
  logic           underrun;
  logic           clear_flags = 1'b0;
  logic           i2s_mclk;
  logic           sclk = 1'b0;
  logic           lrclk = 1'b1;
  logic           din;
  logic           dout = 1'b0;

  always #5 clk = ~clk;

  i2s_stream_engine #(.DATA_W(W), .FIFO_DEPTH(8), .MCLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_level(tx_level),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
    .underrun(underrun), .clear_flags(clear_flags),
    .i2s_mclk(i2s_mclk), .i2s_sclk(sclk), .i2s_lrclk(lrclk),
    .i2s_din(din), .i2s_dout(dout)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int rise16_cyc = 0;
  logic [W-1:0]   got_l = '0, got_r = '0;
  logic [31:0]    cap_l = '0, cap_r = '0;
  logic [2*W-1:0] model_q[$];
  logic           model_unr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One system clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      got_l = rx_left;
      got_r = rx_right;
      valid_cyc = cyc;
    end
  endtask

  // One SCLK period: codec changes LRCLK/DOUT at the fall, samples DIN at the rise.
  task automatic sbit(input logic lr, input logic d, input int k, input bit clr);
    sclk = 1'b0; lrclk = lr; dout = d;
    repeat (8) tick();
    sclk = 1'b1;
    if (k < 32)      cap_l[31-k] = din;
    else if (k < 64) cap_r[63-k] = din;
    if (k == 32 + W) rise16_cyc = cyc;
    if (clr) begin
      clear_flags = 1'b1;
      repeat (3) tick();
      clear_flags = 1'b0;
      repeat (5) tick();
    end else begin
      repeat (8) tick();
    end
  endtask

  task automatic frame_part(input logic [W-1:0] dl, input logic [W-1:0] dr,
                            input int k0, input int k1, input bit clr);
    for (int k = k0; k <= k1; k++) begin
      int j;
      logic [W-1:0] w;
      logic lr;
      lr = (k >= 32);
      j  = k % 32;
      w  = lr ? dr : dl;
      sbit(lr, (j >= 1 && j <= W) ? w[W-j] : 1'b0, k, clr && (k == 0));
    end
  endtask

  task automatic warmup();
    for (int i = 0; i < 4; i++) sbit(1'b1, 1'b0, 99, 1'b0);
  endtask

  task automatic push(input logic [2*W-1:0] d);
    chk("push_ready", tx_ready, (model_q.size() < 8));
    tx_data = d; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    if (model_q.size() < 8) model_q.push_back(d);
  endtask

  // Full enabled frame, checked against the queue model.
  task automatic checked_frame(input string tag, input logic [W-1:0] dl,
                               input logic [W-1:0] dr, input bit clr);
    logic [W-1:0] el, er;
    logic [31:0]  exp_l, exp_r;
    if (model_q.size() > 0) begin
      if (clr) model_unr = 1'b0;
      {el, er} = model_q.pop_front();
    end else begin
      el = '0; er = '0; model_unr = 1'b1;
    end
    exp_l = {1'b0, el, {(31-W){1'b0}}};
    exp_r = {1'b0, er, {(31-W){1'b0}}};
    valid_cnt = 0; valid_cyc = 0; rise16_cyc = 0;
    frame_part(dl, dr, 0, 63, clr);
    chk({tag, "_din_left"}, cap_l, exp_l);
    chk({tag, "_din_right"}, cap_r, exp_r);
    chk({tag, "_valid_pulses"}, valid_cnt, 1);
    chk({tag, "_rx_left"}, got_l, dl);
    chk({tag, "_rx_right"}, got_r, dr);
    chk({tag, "_valid_latency"}, valid_cyc - rise16_cyc, 3);
    chk({tag, "_level"}, tx_level, model_q.size());
    chk({tag, "_ready"}, tx_ready, (model_q.size() < 8));
    chk({tag, "_underrun"}, underrun, model_unr);
  endtask

  initial begin
    int highs, toggles;
    logic prev;
    logic [W-1:0] dl, dr;

    // Reset state
    repeat (3) tick();
    chk("rst_mclk", i2s_mclk, 0);
    chk("rst_din", din, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_level", tx_level, 0);
    chk("rst_rx", {rx_left, rx_right, rx_valid, underrun}, 0);
    reset_n = 1'b1;
    prev = i2s_mclk; highs = 0; toggles = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i2s_mclk === 1'b1) highs++;
      if (i2s_mclk !== prev) toggles++;
      prev = i2s_mclk;
    end
    chk("mclk_high_cycles", highs, 8);
    chk("mclk_toggles", toggles, 8);
    chk("idle_outputs", {din, rx_left, rx_right, rx_valid, underrun}, 0);
    chk("idle_level", tx_level, 0);

    // Directed first frame
    push({16'hA5C3, 16'h0F0F});
    enable = 1'b1;
    warmup();
    checked_frame("first", 16'h1234, 16'hBEEF, 1'b0);

    // Randomised frames, 0..2 pushes each
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(0, 2);
      for (int p = 0; p < n; p++) push($urandom);
      dl = $urandom; dr = $urandom;
      checked_frame("rand", dl, dr, 1'b0);
    end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0; tick();
    model_unr = 1'b0;
    chk("rand_clear", underrun, 0);

    // Fill the FIFO with SCLK idle, then one frame pops exactly one entry
    enable = 1'b0;
    tick();
    while (model_q.size() < 8) push($urandom);
    chk("full_ready", tx_ready, 0);
    chk("full_level", tx_level, 8);
    push($urandom);
    chk("full_level_after_extra", tx_level, 8);
    enable = 1'b1;
    checked_frame("drain", $urandom, $urandom, 1'b0);
    while (model_q.size() > 0) checked_frame("drain", $urandom, $urandom, 1'b0);

    // Underrun set, clear alone, clear during an empty left start
    checked_frame("empty", $urandom, $urandom, 1'b0);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0; tick();
    model_unr = 1'b0;
    chk("clear_alone", underrun, 0);
    checked_frame("clear_vs_set", $urandom, $urandom, 1'b1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0; tick();
    model_unr = 1'b0;

    // Enable mid right slot, then reset mid left slot
    push($urandom);
    push($urandom);
    enable = 1'b0;
    valid_cnt = 0;
    dl = $urandom; dr = $urandom;
    frame_part(dl, dr, 0, 35, 1'b0);
    enable = 1'b1;
    frame_part(dl, dr, 36, 63, 1'b0);
    chk("late_enable_no_pop", tx_level, 2);
    chk("late_enable_no_valid", valid_cnt, 0);
    frame_part(dl, dr, 0, 10, 1'b0);
    void'(model_q.pop_front());
    chk("pop_at_left_start", tx_level, model_q.size());
    reset_n = 1'b0;
    #1;
    chk("midrst_din", din, 0);
    chk("midrst_level", tx_level, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_flags", {rx_valid, underrun, rx_left, rx_right}, 0);
    repeat (2) tick();
    model_q.delete();
    model_unr = 1'b0;
    reset_n = 1'b1;
    valid_cnt = 0;
    cap_r = '1;
    frame_part(dl, dr, 11, 63, 1'b0);
    chk("post_rst_no_valid", valid_cnt, 0);
    chk("post_rst_din_idle", cap_r, 0);
    push($urandom);
    checked_frame("post_rst", $urandom, $urandom, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_stream_engine.md
Name: i2s_stream_engine

Overview:
- Parametrised I2S audio engine between the SoC audio datapath and the SGTL5000 codec on the Arduino header.
- Generates the codec master clock (MCLK) from the system clock using a programmable divider.
- Acts as I2S slave: the codec drives SCLK/LRCLK. The block serialises stereo samples from a TX FIFO onto DIN and deserialises DOUT into stereo RX samples.
- Generalises the fixed divide-by-4 MCLK counter with configurable sample width, divider and FIFO depth, plus underrun reporting.

Parameters:
- DATA_W, 16, bits per channel sample (8..32), MSB first.
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, ≥2); each entry is one stereo pair.
- MCLK_DIV, 4, system clocks per MCLK period (even, ≥2); 4 gives 12.5 MHz from 50 MHz.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  streaming enable; MCLK runs regardless of this input.
- tx_data  in  2*DATA_W  {left, right} stereo pair.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  FIFO not full.
- tx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- rx_left  out  DATA_W  last captured left sample.
- rx_right  out  DATA_W  last captured right sample.
- rx_valid  out  1  one-cycle pulse when a new stereo pair is available.
- underrun  out  1  sticky flag: a frame started with the FIFO empty.
- clear_flags  in  1  clears underrun.
- i2s_mclk  out  1  codec master clock.
- i2s_sclk  in  1  codec bit clock (asynchronous).
- i2s_lrclk  in  1  codec word select (0 = left).
- i2s_din  out  1  serial data to the codec.
- i2s_dout  in  1  serial data from the codec.

Behaviour:
- Reset values: i2s_mclk=0, i2s_din=0, tx_ready=1, tx_level=0, rx_left=rx_right=0, rx_valid=0, underrun=0. FIFO is emptied; slot state is SLOT_IDLE.
- MCLK:
  - Counter 0..MCLK_DIV/2-1; i2s_mclk toggles on wrap, giving a 50% duty cycle.
  - Free-running from reset; not gated by enable.
- Input synchronisation:
  - i2s_sclk, i2s_lrclk and i2s_dout each pass through a 2-flop synchroniser with identical delay.
  - sclk_rise/sclk_fall are one-cycle strobes from the synchronised SCLK and its previous value.
  - Required: SCLK period ≥ 8 clk.
- Slot detection:
  - On each sclk_rise, compare synced LRCLK with its value at the previous sclk_rise.
  - A difference means slot start: 1→0 starts a left slot, 0→1 starts a right slot. bit_idx is reset to 0.
- State machine: SLOT_IDLE, SLOT_LEFT, SLOT_RIGHT.
  - Any state goes to SLOT_IDLE when enable=0.
  - IDLE→LEFT only on a left-slot start while enable=1. An enable asserted mid-frame waits for the next left start.
  - LEFT↔RIGHT on each slot start.
  - A right start seen while in IDLE is ignored.
- TX path:
  - At a left-slot start, pop one FIFO entry: left half loads the shift register, right half is held.
  - If the FIFO is empty at that point: transmit zeros for both slots and set underrun.
  - At a right-slot start, load the held right half.
  - On sclk_fall events 1..DATA_W after slot start, drive the shift MSB onto i2s_din, then shift left.
  - On later falls, and in IDLE, drive i2s_din=0.
- TX FIFO:
  - Push when tx_valid && tx_ready.
  - A pop and a push in the same cycle both take effect. If the FIFO is empty that cycle, the pop finds it empty and signals underrun (no bypass).
  - A full FIFO drops nothing, because tx_ready=0.
  - FIFO contents are retained across enable=0.
- RX path:
  - On sclk_rise events 1..DATA_W after slot start, shift synced DOUT into the left or right capture register; later bits are ignored.
  - After the DATA_W-th capture of a right slot that follows a complete left slot:
    - register rx_left and rx_right;
    - pulse rx_valid for one clk.
  - rx_left and rx_right hold their values until the next update.
- Flags:
  - underrun stays set until clear_flags=1.
  - If set and clear happen in the same cycle, set wins.
- Reset asserted mid-frame: all outputs return immediately to their reset values. After release, the block resynchronises at the next left-slot start.

Decomposition:
- i2s_pkg holds:
  - typedef enum slot_e {SLOT_IDLE, SLOT_LEFT, SLOT_RIGHT};
  - localparam SYNC_STAGES=2.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty, level. It uses the same clk and reset_n.

Test Plan:
- Reset, then run 16 clk → i2s_mclk period is 4 clk at 50% duty; tx_ready=1; tx_level=0; all outputs 0.
- Push {16'hA5C3, 16'h0F0F}, enable=1, codec model at SCLK=clk/16 with 32-bit slots → DIN carries A5C3 MSB first starting at the second SCLK falling edge after LRCLK falls, then 0F0F in the right slot, then zeros to the end of each slot.
- Codec DOUT sends left 16'h1234, right 16'hBEEF → one rx_valid pulse with rx_left=1234, rx_right=BEEF, about 3 clk after the 16th right-slot rising edge.
- Push 8 entries with no SCLK → tx_ready=0, tx_level=8; a 9th tx_valid is not accepted; one left-slot start → tx_level=7, tx_ready=1.
- Enable with an empty FIFO → DIN stays 0 and underrun=1. clear_flags=1 alone clears it; clear_flags during an empty-FIFO left start leaves underrun=1.
- Assert enable during a right slot, then pulse reset_n low mid-left-slot → no pop before the first left start; during reset din=0 and FIFO empty; after release no rx_valid until a full left+right frame completes.
